// File: rtl/crc_stream_arbiter_if.sv
// Stream bundle between two AXI-Stream requesters, the shared CRC engine and the stats outputs.
// The master modport is the arbiter's view; slave is the environment's view.
interface crc_stream_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] s0_axis_tdata;
   logic                  s0_axis_tvalid;
   logic                  s0_axis_tlast;
   logic                  s0_axis_tready;
   logic [DATA_WIDTH-1:0] s1_axis_tdata;
   logic                  s1_axis_tvalid;
   logic                  s1_axis_tlast;
   logic                  s1_axis_tready;
   logic                  crc_init;
   logic [DATA_WIDTH-1:0] crc_data;
   logic                  crc_valid;
   logic                  crc_last;
   logic                  crc_done;
   logic                  crc_flag;
   logic [DATA_WIDTH-1:0] frame_count_out;
   logic [DATA_WIDTH-1:0] error_count_out;
   logic                  frame_error;
   logic                  frame_src;

   modport master (
      input  s0_axis_tdata, s0_axis_tvalid, s0_axis_tlast,
      input  s1_axis_tdata, s1_axis_tvalid, s1_axis_tlast,
      output s0_axis_tready, s1_axis_tready,
      output crc_init, crc_data, crc_valid, crc_last,
      input  crc_done, crc_flag,
      output frame_count_out, error_count_out, frame_error, frame_src
   );

   modport slave (
      output s0_axis_tdata, s0_axis_tvalid, s0_axis_tlast,
      output s1_axis_tdata, s1_axis_tvalid, s1_axis_tlast,
      input  s0_axis_tready, s1_axis_tready,
      input  crc_init, crc_data, crc_valid, crc_last,
      output crc_done, crc_flag,
      input  frame_count_out, error_count_out, frame_error, frame_src
   );
endinterface

// File: rtl/crc_stream_arbiter.sv
// Frame-level round-robin of two streams onto one CRC engine; beats forwarded with zero latency.
// Backpressure: tready follows enable only for the granted channel in STREAM; result stats register one cycle after done/timeout.
module crc_stream_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int DONE_TIMEOUT = 16
) (
   input  logic                 axis_aclk,
   input  logic                 axis_aresetn,
   input  logic                 enable,
   crc_stream_arbiter_if.master bus
);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0]         TIMER_LAST = TW'(DONE_TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [DATA_WIDTH-1:0] CNT_ONE    = DATA_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, INIT, STREAM, WAIT_RES} state_t;

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [DATA_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [DATA_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                  frame_error_q, frame_error_d;
   logic                  frame_src_q, frame_src_d;

   logic g_vld, g_last, stream_rdy, beat_vld, finish, failed;

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         timer_q       <= '0;
         frame_cnt_q   <= '0;
         err_cnt_q     <= '0;
         frame_error_q <= 1'b0;
         frame_src_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         timer_q       <= timer_d;
         frame_cnt_q   <= frame_cnt_d;
         err_cnt_q     <= err_cnt_d;
         frame_error_q <= frame_error_d;
         frame_src_q   <= frame_src_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      timer_d       = timer_q;
      frame_cnt_d   = frame_cnt_q;
      err_cnt_d     = err_cnt_q;
      frame_error_d = 1'b0;
      frame_src_d   = frame_src_q;
      finish        = 1'b0;
      failed        = 1'b0;

      // Granted channel is combinationally steered straight to the engine.
      g_vld      = grant_q ? bus.s1_axis_tvalid : bus.s0_axis_tvalid;
      g_last     = grant_q ? bus.s1_axis_tlast  : bus.s0_axis_tlast;
      stream_rdy = (state_q == STREAM) && enable;
      beat_vld   = stream_rdy && g_vld;

      bus.s0_axis_tready = stream_rdy && !grant_q;
      bus.s1_axis_tready = stream_rdy && grant_q;
      bus.crc_init       = (state_q == INIT);
      bus.crc_data       = grant_q ? bus.s1_axis_tdata : bus.s0_axis_tdata;
      bus.crc_valid      = beat_vld;
      bus.crc_last       = beat_vld && g_last;

      case (state_q)
         IDLE: begin
            if (enable && (bus.s0_axis_tvalid || bus.s1_axis_tvalid)) begin
               grant_d = (bus.s0_axis_tvalid && bus.s1_axis_tvalid) ? ~last_grant_q
                                                                   : ~bus.s0_axis_tvalid;
               state_d = INIT;
            end
         end
         INIT: state_d = STREAM;
         STREAM: begin
            if (beat_vld && g_last) begin
               state_d = WAIT_RES;
               timer_d = '0;
            end
         end
         WAIT_RES: begin
            // A result arriving on the final timeout cycle still wins over the timeout.
            if (bus.crc_done) begin
               finish      = 1'b1;
               failed      = bus.crc_flag;
               frame_src_d = grant_q;
            end else if (timer_q == TIMER_LAST) begin
               finish = 1'b1;
               failed = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         state_d      = IDLE;
         last_grant_d = grant_q;
         frame_cnt_d  = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + CNT_ONE;
         if (failed) begin
            err_cnt_d     = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_ONE;
            frame_error_d = 1'b1;
         end
      end
   end

   assign bus.frame_count_out = frame_cnt_q;
   assign bus.error_count_out = err_cnt_q;
   assign bus.frame_error     = frame_error_q;
   assign bus.frame_src       = frame_src_q;
endmodule

// File: tb/tb_crc_stream_arbiter.sv
// Bench for crc_stream_arbiter: frame-level reference model checked every cycle, plus directed scenarios.
module tb_crc_stream_arbiter;
   localparam int DW   = 8;
   localparam int TO   = 16;
   localparam int CMAX = 2 ** DW - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;

   crc_stream_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   crc_stream_arbiter #(.DATA_WIDTH(DW), .DONE_TIMEOUT(TO)) dut (
      .axis_aclk    (clk),
      .axis_aresetn (rst_n),
      .enable       (enable),
      .bus          (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [DW:0] mem0 [0:1023];
   logic [DW:0] mem1 [0:1023];
   int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
   int flush_req = 0, flush_seen = 0;
   int stray_req = 0, stray_seen = 0;
   int resp_delay = 2;
   bit resp_flag = 1'b0;
   int resp_cnt = -1;
   bit hs0, hs1;

   // Reference model: who owns the engine and where in its frame life it is.
   int m_owner = -1;
   bit m_init = 1'b0;
   int m_wait = -1;
   int m_last = 1;
   int m_frames = 0, m_errors = 0, m_src = 0;
   bit m_err = 1'b0;
   int m_events = 0;

   int cyc = 0, t_last = 0, t_err = 0;
   int beats_fwd = 0, inits_seen = 0, err_pulses = 0;
   bit want_log = 1'b0;
   int glog[$];
   int ev, b0, b1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int ch, input int n, input int base);
      for (int i = 0; i < n; i++) begin
         if (ch == 0) begin
            mem0[wr0] = {(i == n - 1), DW'(base + i)};
            wr0++;
         end else begin
            mem1[wr1] = {(i == n - 1), DW'(base + i)};
            wr1++;
         end
      end
   endtask

   task automatic wait_events(input int tgt, input int budget, input string name);
      int n = 0;
      while (m_events < tgt && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (m_events < tgt) begin
         failures++;
         $display("FAIL %s: completions %0d, needed %0d within %0d cycles", name, m_events, tgt, budget);
      end
   endtask

   task automatic wait_beats(input int tgt, input int budget, input string name);
      int n = 0;
      while (beats_fwd < tgt && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (beats_fwd < tgt) begin
         failures++;
         $display("FAIL %s: beats %0d, needed %0d within %0d cycles", name, beats_fwd, tgt, budget);
      end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0;
      bus.s0_axis_tdata = '0; bus.s0_axis_tvalid = 1'b0; bus.s0_axis_tlast = 1'b0;
      bus.s1_axis_tdata = '0; bus.s1_axis_tvalid = 1'b0; bus.s1_axis_tlast = 1'b0;
      bus.crc_done = 1'b0; bus.crc_flag = 1'b0;
      fork
         begin : main_seq
            repeat (3) @(posedge clk);
            #2;
            chk("reset_frames", bus.frame_count_out, 0);
            chk("reset_tready0", bus.s0_axis_tready, 0);
            rst_n = 1'b1;

            // Single 4-beat frame on s0, held off by enable=0 first.
            push(0, 4, 'h11);
            resp_delay = 2; resp_flag = 1'b0;
            repeat (4) @(posedge clk);
            #2;
            chk("disabled_no_init", inits_seen, 0);
            enable = 1'b1;
            ev = m_events;
            wait_events(ev + 1, 60, "t1_done");
            settle();
            chk("t1_frames", bus.frame_count_out, 1);
            chk("t1_errors", bus.error_count_out, 0);
            chk("t1_src", bus.frame_src, 0);
            chk("t1_inits", inits_seen, 1);
            chk("t1_beats", beats_fwd, 4);

            // Fresh reset, then both channels contend: grants 0,1,0,1.
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            rst_n = 1'b1;
            glog.delete();
            push(0, 3, 'h20); push(1, 3, 'h30); push(0, 3, 'h40); push(1, 3, 'h50);
            ev = m_events;
            wait_events(ev + 4, 120, "t2_done");
            settle();
            chk("rr_count", glog.size(), 4);
            for (int i = 0; i < 4; i++)
               if (i < glog.size()) chk($sformatf("rr_grant%0d", i), glog[i], i % 2);
            chk("t2_frames", bus.frame_count_out, 4);

            // Mismatch, stray done while idle, then a clean frame.
            err_pulses = 0;
            resp_flag = 1'b1;
            push(1, 2, 'h60);
            ev = m_events;
            wait_events(ev + 1, 60, "t3a_done");
            settle();
            chk("t3a_errors", bus.error_count_out, 1);
            chk("t3a_frames", bus.frame_count_out, 5);
            chk("t3a_pulses", err_pulses, 1);
            chk("t3a_src", bus.frame_src, 1);
            stray_req++;
            repeat (4) @(posedge clk);
            #2;
            chk("stray_frames", bus.frame_count_out, 5);
            chk("stray_errors", bus.error_count_out, 1);
            resp_flag = 1'b0;
            push(0, 2, 'h70);
            ev = m_events;
            wait_events(ev + 1, 60, "t3b_done");
            settle();
            chk("t3b_errors", bus.error_count_out, 1);
            chk("t3b_frames", bus.frame_count_out, 6);
            chk("t3b_pulses", err_pulses, 1);
            chk("t3b_src", bus.frame_src, 0);

            // Withheld result on s1 -> timeout 17 cycles after the last beat.
            resp_delay = -1;
            push(1, 2, 'h80);
            ev = m_events;
            wait_events(ev + 1, 80, "t4_timeout");
            settle();
            chk("t4_timeout_gap", t_err - t_last, 17);
            chk("t4_frames", bus.frame_count_out, 7);
            chk("t4_errors", bus.error_count_out, 2);
            chk("t4_pulses", err_pulses, 2);
            chk("t4_src_kept", bus.frame_src, 0);
            resp_delay = 1;
            push(0, 3, 'h90);
            ev = m_events;
            wait_events(ev + 1, 60, "t4b_done");
            settle();
            chk("t4b_frames", bus.frame_count_out, 8);

            // Enable dropped for 5 cycles after beat 2.
            b0 = beats_fwd;
            resp_delay = 2;
            push(0, 4, 'hA0);
            wait_beats(b0 + 2, 40, "t5_two_beats");
            #2;
            enable = 1'b0;
            repeat (5) @(posedge clk);
            #2;
            chk("t5_stall_beats", beats_fwd, b0 + 2);
            enable = 1'b1;
            ev = m_events;
            wait_events(ev + 1, 60, "t5_done");
            settle();
            chk("t5_beats", beats_fwd, b0 + 4);
            chk("t5_frames", bus.frame_count_out, 9);

            // Reset during beat 2, then a fresh frame.
            b0 = beats_fwd;
            push(0, 4, 'hB0);
            wait_beats(b0 + 1, 40, "t6_first_beat");
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_tready0", bus.s0_axis_tready, 0);
            chk("async_valid", bus.crc_valid, 0);
            chk("async_frames", bus.frame_count_out, 0);
            chk("async_errors", bus.error_count_out, 0);
            flush_req++;
            repeat (3) @(posedge clk);
            #2;
            rst_n = 1'b1;
            inits_seen = 0;
            beats_fwd = 0;
            push(0, 4, 'hC0);
            ev = m_events;
            wait_events(ev + 1, 60, "t6_done");
            settle();
            chk("t6_frames", bus.frame_count_out, 1);
            chk("t6_errors", bus.error_count_out, 0);
            chk("t6_inits", inits_seen, 1);
            chk("t6_beats", beats_fwd, 4);

            // Saturation: 260 failing single-beat frames.
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            rst_n = 1'b1;
            resp_delay = 1; resp_flag = 1'b1;
            for (int i = 0; i < 260; i++) push(0, 1, i);
            ev = m_events;
            wait_events(ev + 260, 2600, "t7_done");
            settle();
            chk("sat_frames", bus.frame_count_out, 255);
            chk("sat_errors", bus.error_count_out, 255);
         end
         begin : monitor
            bit e_stream, e_rdy0, e_rdy1, e_valid, e_last, o_last;
            int o_data;
            forever begin
               @(negedge clk);
               cyc++;
               hs0 = 1'b0; hs1 = 1'b0;
               if (!rst_n) begin
                  chk("rst_tready0", bus.s0_axis_tready, 0);
                  chk("rst_tready1", bus.s1_axis_tready, 0);
                  chk("rst_init", bus.crc_init, 0);
                  chk("rst_valid", bus.crc_valid, 0);
                  chk("rst_last", bus.crc_last, 0);
                  chk("rst_ferr", bus.frame_error, 0);
                  chk("rst_fcnt", bus.frame_count_out, 0);
                  chk("rst_ecnt", bus.error_count_out, 0);
                  chk("rst_src", bus.frame_src, 0);
                  m_owner = -1; m_init = 1'b0; m_wait = -1; m_last = 1;
                  m_frames = 0; m_errors = 0; m_src = 0; m_err = 1'b0;
                  resp_cnt = -1;
               end else begin
                  e_stream = (m_owner >= 0) && !m_init && (m_wait < 0);
                  e_rdy0   = e_stream && (m_owner == 0) && enable;
                  e_rdy1   = e_stream && (m_owner == 1) && enable;
                  e_valid  = (e_rdy0 && bus.s0_axis_tvalid) || (e_rdy1 && bus.s1_axis_tvalid);
                  o_last   = (m_owner == 1) ? bus.s1_axis_tlast : bus.s0_axis_tlast;
                  o_data   = (m_owner == 1) ? int'(bus.s1_axis_tdata) : int'(bus.s0_axis_tdata);
                  e_last   = e_valid && o_last;
                  chk("tready0", bus.s0_axis_tready, e_rdy0);
                  chk("tready1", bus.s1_axis_tready, e_rdy1);
                  chk("crc_init", bus.crc_init, m_init);
                  chk("crc_valid", bus.crc_valid, e_valid);
                  chk("crc_last", bus.crc_last, e_last);
                  if (e_valid) chk("crc_data", bus.crc_data, o_data);
                  chk("frame_count", bus.frame_count_out, m_frames);
                  chk("error_count", bus.error_count_out, m_errors);
                  chk("frame_error", bus.frame_error, m_err);
                  chk("frame_src", bus.frame_src, m_src);

                  if (bus.crc_init) begin inits_seen++; want_log = 1'b1; end
                  if (bus.crc_valid) beats_fwd++;
                  if (want_log && bus.crc_valid) begin
                     glog.push_back(bus.s1_axis_tready ? 1 : 0);
                     want_log = 1'b0;
                  end
                  if (bus.frame_error) begin err_pulses++; t_err = cyc; end
                  if (bus.crc_valid && bus.crc_last) begin
                     t_last = cyc;
                     if (resp_delay > 0) resp_cnt = resp_delay;
                  end
                  hs0 = bus.s0_axis_tvalid && bus.s0_axis_tready;
                  hs1 = bus.s1_axis_tvalid && bus.s1_axis_tready;

                  m_err = 1'b0;
                  if (m_owner < 0) begin
                     if (enable && (bus.s0_axis_tvalid || bus.s1_axis_tvalid)) begin
                        if (bus.s0_axis_tvalid && bus.s1_axis_tvalid) m_owner = 1 - m_last;
                        else m_owner = bus.s0_axis_tvalid ? 0 : 1;
                        m_init = 1'b1;
                     end
                  end else if (m_init) begin
                     m_init = 1'b0;
                  end else if (m_wait < 0) begin
                     if (e_last) m_wait = 0;
                  end else if (bus.crc_done || m_wait == TO - 1) begin
                     m_frames = (m_frames < CMAX) ? m_frames + 1 : m_frames;
                     if (!bus.crc_done || bus.crc_flag) begin
                        m_errors = (m_errors < CMAX) ? m_errors + 1 : m_errors;
                        m_err = 1'b1;
                     end
                     if (bus.crc_done) m_src = m_owner;
                     m_last = m_owner;
                     m_owner = -1;
                     m_wait = -1;
                     m_events++;
                  end else begin
                     m_wait++;
                  end
               end

               @(posedge clk);
               #1;
               if (hs0) rd0++;
               if (hs1) rd1++;
               if (flush_req != flush_seen) begin
                  rd0 = wr0; rd1 = wr1; flush_seen = flush_req;
               end
               bus.s0_axis_tvalid = (rd0 < wr0);
               {bus.s0_axis_tlast, bus.s0_axis_tdata} = (rd0 < wr0) ? mem0[rd0] : '0;
               bus.s1_axis_tvalid = (rd1 < wr1);
               {bus.s1_axis_tlast, bus.s1_axis_tdata} = (rd1 < wr1) ? mem1[rd1] : '0;
               bus.crc_done = 1'b0;
               bus.crc_flag = 1'b1;
               if (resp_cnt > 0) begin
                  resp_cnt--;
                  if (resp_cnt == 0) begin
                     bus.crc_done = 1'b1;
                     bus.crc_flag = resp_flag;
                     resp_cnt = -1;
                  end
               end
               if (stray_req != stray_seen) begin
                  bus.crc_done = 1'b1;
                  stray_seen = stray_req;
               end
            end
         end
         begin : watchdog
            #300000;
            failures++;
            $display("FAIL watchdog: run exceeded time limit at %0t", $time);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "watchdog expired");
         end
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/crc_stream_arbiter.md
CRC_STREAM_ARBITER -- requirements
Module: crc_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, beat width and counter width.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 16, max cycles to wait for crc_done after last beat.
REQ-003 axis_aclk  in  1  sole clock; all state on rising edge.
REQ-004 axis_aresetn  in  1  reset, asynchronous and active-low.
REQ-005 enable  in  1  global run; 0 = issue no new grants and hold all tready low.
REQ-006 s0_axis_tdata / s1_axis_tdata  in  DATA_WIDTH  requester beat data.
REQ-007 s0_axis_tvalid / s1_axis_tvalid  in  1  requester beat valid.
REQ-008 s0_axis_tlast / s1_axis_tlast  in  1  last beat of frame.
REQ-009 s0_axis_tready / s1_axis_tready  out  1  beat accepted when tvalid&tready.
REQ-010 crc_init  out  1  one-cycle pulse clearing the shared CRC engine.
REQ-011 crc_data  out  DATA_WIDTH  beat forwarded to engine.
REQ-012 crc_valid / crc_last  out  1  beat strobe / last-beat marker to engine.
REQ-013 crc_done  in  1  engine result-valid pulse.
REQ-014 crc_flag  in  1  engine result, 1 = CRC mismatch; sampled only with crc_done.
REQ-015 frame_count_out  out  DATA_WIDTH  completed frames, both channels.
REQ-016 error_count_out  out  DATA_WIDTH  failed frames (mismatch or timeout).
REQ-017 frame_error  out  1  one-cycle pulse per failed frame.
REQ-018 frame_src  out  1  channel of most recently completed frame.

Function
REQ-019 SHALL implement FSM IDLE -> INIT -> STREAM -> WAIT_RES -> IDLE.
REQ-020 IDLE: when enable=1 and any tvalid=1, grant next cycle and go to INIT; otherwise stay.
REQ-021 Arbitration SHALL be frame-level round-robin: on a tie, grant the channel not equal to last_grant; last_grant resets to 1 (channel 0 wins the first tie).
REQ-022 INIT: crc_init=1 for exactly one cycle; all tready=0; then go to STREAM.
REQ-023 STREAM: granted tready=enable, other tready=0; crc_data=granted tdata, crc_valid=granted tvalid&tready, crc_last=granted tlast&crc_valid; zero added latency (combinational forward).
REQ-024 STREAM: handshake with tlast=1 SHALL go to WAIT_RES; grant SHALL NOT change mid-frame.
REQ-025 enable=0 in STREAM SHALL stall (tready=0) without aborting the frame; resume on enable=1.
REQ-026 WAIT_RES: all tready=0; on crc_done, increment frame_count_out; if crc_flag=1 also increment error_count_out and pulse frame_error; update frame_src and last_grant; go to IDLE.
REQ-027 WAIT_RES: if crc_done is absent for DONE_TIMEOUT cycles after entry, treat the frame as failed (both counters +1, frame_error pulse), update last_grant, and go to IDLE.
REQ-028 Counter and frame_error updates SHALL be registered and visible the cycle after the crc_done or timeout edge.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 crc_done outside WAIT_RES SHALL be ignored.
REQ-031 Minimum frame turnaround: an N-beat frame occupies 1 IDLE + 1 INIT + N STREAM cycles + result wait.

Reset
REQ-032 axis_aresetn=0 SHALL immediately force IDLE, all tready/crc_init/crc_valid/crc_last/frame_error=0, counters=0, frame_src=0, last_grant=1.
REQ-033 Reset mid-frame SHALL discard the partial frame and count nothing; the first grant after release starts with crc_init.

Verification
REQ-034 Single 4-beat frame on s0, crc_done+crc_flag=0 two cycles after last beat -> one crc_init pulse, 4 crc_valid with crc_last on beat 4, frame_count_out=1, error_count_out=0, frame_src=0.
REQ-035 s0 and s1 each present continuous 3-beat frames -> grants alternate 0,1,0,1; after 4 results frame_count_out=4; no interleaved beats.
REQ-036 crc_done with crc_flag=1 -> frame_error high exactly one cycle, error_count_out=1; the next frame with flag=0 leaves it at 1.
REQ-037 crc_done withheld after the last beat -> after 16 cycles frame_error pulses, both counters +1, FSM back to IDLE and accepts a new frame.
REQ-038 enable dropped for 5 cycles mid-frame -> tready=0 and crc_valid=0 for those cycles; frame completes intact; beat count is unchanged.
REQ-039 axis_aresetn asserted during beat 2 of 4 -> outputs and counters cleared asynchronously; after release a fresh frame gets a new crc_init and frame_count_out=1.
